// File: rtl/rtc_ciclo_lectura.sv
// Read-cycle generator for the V3023 RTC multiplexed address/data bus.
// Runs an address phase (WR strobe carrying Dir), then a data phase (RD strobe), and returns the byte read.
`timescale 1ns/1ps

module rtc_ciclo_lectura #(
  parameter int T_AS  = 2,
  parameter int T_WR  = 10,
  parameter int T_AH  = 3,
  parameter int T_GAP = 4,
  parameter int T_RD  = 10,
  parameter int T_REC = 5
) (
  input  logic       Clock_in,
  input  logic       Reset,
  input  logic       ciclo,
  input  logic [7:0] Dir,
  input  logic [7:0] Dato_in,
  output logic [7:0] Dato_out,
  output logic       Bus_oe,
  output logic       A_D,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic [7:0] Dato_leido,
  output logic       Ocupado,
  output logic       Fin
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AS,
    S_AWR,
    S_AH,
    S_GAP,
    S_DRD,
    S_REC,
    S_DONE
  } state_t;

  typedef struct packed {
    logic a_d;
    logic cs;
    logic wr;
    logic rd;
    logic bus_oe;
    logic ocupado;
    logic fin;
  } pins_t;

  // Each timed state preloads its duration minus one; the state ends on the edge after zero.
  localparam logic [6:0] LD_AS  = 7'(T_AS  - 1);
  localparam logic [6:0] LD_WR  = 7'(T_WR  - 1);
  localparam logic [6:0] LD_AH  = 7'(T_AH  - 1);
  localparam logic [6:0] LD_GAP = 7'(T_GAP - 1);
  localparam logic [6:0] LD_RD  = 7'(T_RD  - 1);
  localparam logic [6:0] LD_REC = 7'(T_REC - 1);

  localparam pins_t PINS_IDLE = '{a_d: 1'b1, cs: 1'b1, wr: 1'b1, rd: 1'b1,
                                  bus_oe: 1'b0, ocupado: 1'b0, fin: 1'b0};

  state_t     state_reg, state_next;
  logic [6:0] cnt_reg, cnt_next;
  pins_t      pins_reg, pins_next;
  logic       expired;

  assign expired = (cnt_reg == 7'd0);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg - 7'd1;
    unique case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (ciclo) begin
          state_next = S_AS;
          cnt_next   = LD_AS;
        end
      end
      S_AS:  if (expired) begin state_next = S_AWR; cnt_next = LD_WR;  end
      S_AWR: if (expired) begin state_next = S_AH;  cnt_next = LD_AH;  end
      S_AH:  if (expired) begin state_next = S_GAP; cnt_next = LD_GAP; end
      S_GAP: if (expired) begin state_next = S_DRD; cnt_next = LD_RD;  end
      S_DRD: if (expired) begin state_next = S_REC; cnt_next = LD_REC; end
      S_REC: if (expired) begin state_next = S_DONE; cnt_next = '0;    end
      S_DONE: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Pin levels are decoded from the upcoming state so they register together with it.
  always_comb begin
    pins_next = PINS_IDLE;
    unique case (state_next)
      S_AS, S_AH: pins_next = '{a_d: 1'b0, cs: 1'b1, wr: 1'b1, rd: 1'b1,
                                bus_oe: 1'b1, ocupado: 1'b1, fin: 1'b0};
      S_AWR:      pins_next = '{a_d: 1'b0, cs: 1'b0, wr: 1'b0, rd: 1'b1,
                                bus_oe: 1'b1, ocupado: 1'b1, fin: 1'b0};
      S_GAP, S_REC: pins_next = '{a_d: 1'b1, cs: 1'b1, wr: 1'b1, rd: 1'b1,
                                  bus_oe: 1'b0, ocupado: 1'b1, fin: 1'b0};
      S_DRD:      pins_next = '{a_d: 1'b1, cs: 1'b0, wr: 1'b1, rd: 1'b0,
                                bus_oe: 1'b0, ocupado: 1'b1, fin: 1'b0};
      S_DONE:     pins_next = '{a_d: 1'b1, cs: 1'b1, wr: 1'b1, rd: 1'b1,
                                bus_oe: 1'b0, ocupado: 1'b1, fin: 1'b1};
      default:    pins_next = PINS_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge Clock_in or negedge Reset) begin
    if (!Reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      pins_reg   <= PINS_IDLE;
      Dato_out   <= '0;
      Dato_leido <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pins_reg  <= pins_next;
      if (state_reg == S_IDLE && ciclo) begin
        Dato_out <= Dir;
      end
      // RD is still low at this edge, so the RTC is driving valid data.
      if (state_reg == S_DRD && expired) begin
        Dato_leido <= Dato_in;
      end
    end
  end

  assign A_D     = pins_reg.a_d;
  assign CS      = pins_reg.cs;
  assign WR      = pins_reg.wr;
  assign RD      = pins_reg.rd;
  assign Bus_oe  = pins_reg.bus_oe;
  assign Ocupado = pins_reg.ocupado;
  assign Fin     = pins_reg.fin;

endmodule

// File: tb/tb_rtc_ciclo_lectura.sv
// Directed bench for rtc_ciclo_lectura: default-timing instance plus an all-ones timing instance,
// with a simple RTC model that drives rtc_byte whenever RD is low.
`timescale 1ns/1ps

module tb_rtc_ciclo_lectura;

  typedef struct {
    logic [7:0] dir;
    logic [7:0] rtc;
    logic [7:0] exp_leido;
  } vec_t;

  typedef struct {
    int ad_low;
    int wr_low;
    int rd_low;
    int occ;
    int fin;
    int strobe_bad;
    int oe_bad;
    int dout_bad;
    int leido_chg;
    int ad_low1;
    int wr_low1;
    int rd_low1;
  } mon_t;

  logic       Clock_in = 1'b0;
  logic       Reset;
  logic       ciclo0, ciclo1;
  logic [7:0] Dir;
  logic [7:0] rtc_byte;
  logic [7:0] exp_dir;

  logic [7:0] din0, dout0, leido0;
  logic       oe0, ad0, cs0, wr0, rd0, ocup0, fin0;
  logic [7:0] din1, dout1, leido1;
  logic       oe1, ad1, cs1, wr1, rd1, ocup1, fin1;

  int   total = 0;
  int   bad   = 0;
  mon_t mon = '{default: 0};
  mon_t base;
  logic [7:0] prev_leido = 8'h00;

  always #5 Clock_in = ~Clock_in;

  assign din0 = (rd0 == 1'b0) ? rtc_byte : 8'h00;
  assign din1 = (rd1 == 1'b0) ? rtc_byte : 8'h00;

  rtc_ciclo_lectura dut0 (
    .Clock_in  (Clock_in),
    .Reset     (Reset),
    .ciclo     (ciclo0),
    .Dir       (Dir),
    .Dato_in   (din0),
    .Dato_out  (dout0),
    .Bus_oe    (oe0),
    .A_D       (ad0),
    .CS        (cs0),
    .WR        (wr0),
    .RD        (rd0),
    .Dato_leido(leido0),
    .Ocupado   (ocup0),
    .Fin       (fin0)
  );

  rtc_ciclo_lectura #(
    .T_AS(1), .T_WR(1), .T_AH(1), .T_GAP(1), .T_RD(1), .T_REC(1)
  ) dut1 (
    .Clock_in  (Clock_in),
    .Reset     (Reset),
    .ciclo     (ciclo1),
    .Dir       (Dir),
    .Dato_in   (din1),
    .Dato_out  (dout1),
    .Bus_oe    (oe1),
    .A_D       (ad1),
    .CS        (cs1),
    .WR        (wr1),
    .RD        (rd1),
    .Dato_leido(leido1),
    .Ocupado   (ocup1),
    .Fin       (fin1)
  );

  // Free-running per-cycle monitor; tests compare deltas against a snapshot.
  always @(negedge Clock_in) begin
    if (ad0 == 1'b0) mon.ad_low++;
    if (cs0 == 1'b0 && wr0 == 1'b0) mon.wr_low++;
    if (cs0 == 1'b0 && rd0 == 1'b0) mon.rd_low++;
    if (ocup0 == 1'b1) mon.occ++;
    if (fin0 == 1'b1) mon.fin++;
    if (wr0 == 1'b0 && rd0 == 1'b0) mon.strobe_bad++;
    if (oe0 == 1'b1 && rd0 == 1'b0) mon.oe_bad++;
    if (wr0 == 1'b0 && dout0 !== exp_dir) mon.dout_bad++;
    if (leido0 !== prev_leido) mon.leido_chg++;
    prev_leido = leido0;
    if (ad1 == 1'b0) mon.ad_low1++;
    if (cs1 == 1'b0 && wr1 == 1'b0) mon.wr_low1++;
    if (cs1 == 1'b0 && rd1 == 1'b0) mon.rd_low1++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a request to dut0; returns just after the acceptance edge.
  task automatic accept0(input logic [7:0] d, input logic [7:0] r);
    Dir      = d;
    rtc_byte = r;
    exp_dir  = d;
    ciclo0   = 1'b1;
    @(posedge Clock_in);
    #1;
    base = mon;
  endtask

  // Counts negedges after the acceptance edge until Fin is seen; 0 means timeout.
  task automatic wait_done(input bit sel, input bit hold, input bit toggle, output int lat);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge Clock_in);
      if (!hold) begin
        if (sel) ciclo1 = 1'b0;
        else     ciclo0 = 1'b0;
      end
      if (toggle) begin
        if (rd0 == 1'b0) begin
          ciclo0 = k[0];
          Dir    = k[0] ? 8'hAA : 8'h55;
        end else begin
          ciclo0 = 1'b0;
        end
      end
      if ((sel ? fin1 : fin0) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  vec_t vecs[4];
  int   lat;
  bit   found;

  initial begin
    vecs[0] = '{dir: 8'h21, rtc: 8'h59, exp_leido: 8'h59};
    vecs[1] = '{dir: 8'h7F, rtc: 8'hA5, exp_leido: 8'hA5};
    vecs[2] = '{dir: 8'hFF, rtc: 8'h00, exp_leido: 8'h00};
    vecs[3] = '{dir: 8'h00, rtc: 8'hFF, exp_leido: 8'hFF};

    Reset = 1'b1; ciclo0 = 1'b0; ciclo1 = 1'b0;
    Dir = 8'h00; rtc_byte = 8'h00; exp_dir = 8'h00;
    #1 Reset = 1'b0;
    #1;
    check("rst_pins",   {ad0, cs0, wr0, rd0}, 4'hF);
    check("rst_oe",     oe0, 1'b0);
    check("rst_ocup",   ocup0, 1'b0);
    check("rst_fin",    fin0, 1'b0);
    check("rst_leido",  leido0, 8'h00);
    check("rst_dout",   dout0, 8'h00);
    repeat (2) @(posedge Clock_in);
    @(negedge Clock_in) Reset = 1'b1;
    @(posedge Clock_in);
    #1;

    // Reset asserted in the middle of the WR strobe.
    accept0(8'h3C, 8'h11);
    ciclo0 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (wr0 == 1'b0) begin
        found = 1'b1;
        break;
      end
      @(posedge Clock_in);
      #1;
    end
    check("reach_awr", found, 1'b1);
    #2 Reset = 1'b0;
    #1;
    check("midrst_pins",  {ad0, cs0, wr0, rd0}, 4'hF);
    check("midrst_oe",    oe0, 1'b0);
    check("midrst_ocup",  ocup0, 1'b0);
    check("midrst_dout",  dout0, 8'h00);
    @(negedge Clock_in) Reset = 1'b1;
    @(posedge Clock_in);
    #1;
    base = mon;
    repeat (5) @(posedge Clock_in);
    #1;
    check("post_rst_occ",   mon.occ - base.occ, 0);
    check("post_rst_adlow", mon.ad_low - base.ad_low, 0);
    check("post_rst_ocup",  ocup0, 1'b0);

    // Table of single reads with full timing checks.
    for (int i = 0; i < 4; i++) begin
      accept0(vecs[i].dir, vecs[i].rtc);
      wait_done(1'b0, 1'b0, 1'b0, lat);
      check($sformatf("v%0d_lat", i), lat, 35);
      check($sformatf("v%0d_leido", i), leido0, vecs[i].exp_leido);
      repeat (2) @(posedge Clock_in);
      #1;
      check($sformatf("v%0d_fin_width", i), mon.fin - base.fin, 1);
      check($sformatf("v%0d_ad_low", i), mon.ad_low - base.ad_low, 15);
      check($sformatf("v%0d_wr_low", i), mon.wr_low - base.wr_low, 10);
      check($sformatf("v%0d_rd_low", i), mon.rd_low - base.rd_low, 10);
      check($sformatf("v%0d_ocup", i), mon.occ - base.occ, 35);
      check($sformatf("v%0d_wr_rd", i), mon.strobe_bad - base.strobe_bad, 0);
      check($sformatf("v%0d_oe_rd", i), mon.oe_bad - base.oe_bad, 0);
      check($sformatf("v%0d_dout", i), mon.dout_bad - base.dout_bad, 0);
      check($sformatf("v%0d_leido_chg", i), mon.leido_chg - base.leido_chg, 1);
    end

    // ciclo held high: two back-to-back reads, one IDLE cycle between them.
    accept0(8'h22, 8'h3A);
    Dir = 8'h23;
    wait_done(1'b0, 1'b1, 1'b0, lat);
    check("b2b_lat1",   lat, 35);
    check("b2b_leido1", leido0, 8'h3A);
    check("b2b_dout1",  mon.dout_bad - base.dout_bad, 0);
    rtc_byte = 8'hB7;
    @(posedge Clock_in);
    #1;
    check("b2b_idle_ocup", ocup0, 1'b0);
    exp_dir = 8'h23;
    @(posedge Clock_in);
    #1;
    base = mon;
    check("b2b_accept2", ocup0, 1'b1);
    check("b2b_dir2",    dout0, 8'h23);
    wait_done(1'b0, 1'b0, 1'b0, lat);
    check("b2b_lat2",   lat, 35);
    check("b2b_leido2", leido0, 8'hB7);
    check("b2b_dout2",  mon.dout_bad - base.dout_bad, 0);
    repeat (2) @(posedge Clock_in);
    #1;

    // ciclo and Dir toggled during the RD strobe.
    accept0(8'h4E, 8'hC3);
    wait_done(1'b0, 1'b0, 1'b1, lat);
    check("tog_lat",   lat, 35);
    check("tog_leido", leido0, 8'hC3);
    repeat (4) @(posedge Clock_in);
    #1;
    check("tog_fin_once",  mon.fin - base.fin, 1);
    check("tog_leido_chg", mon.leido_chg - base.leido_chg, 1);
    check("tog_dout",      mon.dout_bad - base.dout_bad, 0);
    check("tog_no_restart", mon.occ - base.occ, 35);
    check("tog_idle",      ocup0, 1'b0);

    // Minimum timing on the second instance.
    Dir      = 8'h6B;
    rtc_byte = 8'h9D;
    ciclo1   = 1'b1;
    @(posedge Clock_in);
    #1;
    base = mon;
    wait_done(1'b1, 1'b0, 1'b0, lat);
    check("min_lat",   lat, 7);
    check("min_leido", leido1, 8'h9D);
    repeat (2) @(posedge Clock_in);
    #1;
    check("min_ad_low", mon.ad_low1 - base.ad_low1, 3);
    check("min_wr_low", mon.wr_low1 - base.wr_low1, 1);
    check("min_rd_low", mon.rd_low1 - base.rd_low1, 1);
    check("min_dout",   dout1, 8'h6B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
